serial_transmit: RTL and testbench
==================================

SERIAL_TRANSMIT -- requirements
Module: serial_transmit

Interface
REQ-001 Parameter BIT_CLKS, 8, clocks per start/data bit; SHALL match the downstream receiver's 8-clock bit period.
REQ-002 Parameter STOP_CLKS, 16, clocks the line SHALL be held high after data bit 15 (receiver realignment guard).
REQ-003 Clock  input  1  single clock; all state SHALL change on posedge Clock only.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 DataIn  input  16  word to send; SHALL be sampled only on an accept edge.
REQ-006 InValid  input  1  DataIn holds a word to send.
REQ-007 Ready  output  1  block can accept a word this cycle; accept = InValid && Ready at posedge.
REQ-008 Transmit  output  1  registered serial line, idle high; drives the receiver's Receive input.
REQ-009 Busy  output  1  high while a frame (start, data, stop) is on the line.
REQ-010 Done  output  1  one-cycle pulse on the final stop-bit clock of each frame.

Function
REQ-011 Frame SHALL be: start bit (0, BIT_CLKS clocks), DataIn[0] to DataIn[15] LSB first (BIT_CLKS clocks each), stop (1, STOP_CLKS clocks); default total 152 clocks.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; IDLE->START on accept; START->DATA after BIT_CLKS; DATA->STOP after 16th bit; STOP->IDLE or STOP->START after STOP_CLKS.
REQ-013 Accept in IDLE with hold empty SHALL load the shift register directly; Transmit SHALL be 0 from the clock after the accept edge.
REQ-014 Accept while Busy SHALL store the word in a one-entry hold register; Ready SHALL be 0 while hold is full.
REQ-015 Ready SHALL be 1 whenever hold is empty, including during a frame.
REQ-016 At the end of STOP with hold full: hold moves to the shift register, FSM enters START with no idle gap, and Ready returns to 1 the next cycle.
REQ-017 At the end of STOP with hold empty and an accept on the same edge: the accepted word SHALL start immediately (STOP->START), not be held.
REQ-018 Bit counter 0..15 and clock counter 0..max(BIT_CLKS,STOP_CLKS)-1 SHALL wrap to 0 at every bit/state boundary; no other arithmetic.
REQ-019 Transmit SHALL be 1 in IDLE and STOP; it SHALL never glitch within a bit period.
REQ-020 Done SHALL assert on the last STOP clock even if a back-to-back frame follows.
REQ-021 DataIn changes when not accepting SHALL have no effect on the line.

Reset
REQ-022 Reset SHALL force immediately: state IDLE, Transmit 1, Ready 1, Busy 0, Done 0, hold empty, counters 0, shift register 0.
REQ-023 Reset mid-frame SHALL abandon the frame and held word; line returns high (receiver may emit one corrupt word; accepted).
REQ-024 First accept after Reset release SHALL be honoured on the first posedge with Reset low.

Structure
REQ-025 Package serial_pkg SHALL hold DATA_BITS=16, default BIT_CLKS/STOP_CLKS, and the FSM state type, shared with the receiver.
REQ-026 One sub-module serial_bit_timer (load value, tick output) is natural; a flat implementation is also acceptable.

Verification
REQ-027 Reset, accept 16'hA5C3 -> Transmit low cycles 1-8, then bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 at 8 clocks each, high 16 clocks, Done at clock 152.
REQ-028 Loopback into the existing receiver, send 16'h0000, 16'hFFFF, 16'h8001 -> receiver DataOut matches each with one Valid pulse per word.
REQ-029 Accept 16'h1234 then 16'h5678 during frame 1 -> Ready low until frame 2 starts, zero idle gap, both received intact.
REQ-030 Third InValid while hold full -> not accepted (Ready 0), word sent only after retry.
REQ-031 Assert Reset at clock 70 of a frame -> Transmit 1, Busy 0, Ready 1 asynchronously; next accepted word 16'h00FF sent correctly.
REQ-032 Accept on the final STOP edge with hold empty -> START begins next cycle, Done pulses once.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the 16-bit serial link (transmitter and receiver).
package serial_pkg;

  localparam int DATA_BITS     = 16;
  localparam int DEF_BIT_CLKS  = 8;
  localparam int DEF_STOP_CLKS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } serial_state_t;

  // Width of a counter that must reach the longer of the two bit periods.
  function automatic int count_width(input int bit_clks, input int stop_clks);
    int longest;
    longest = (bit_clks > stop_clks) ? bit_clks : stop_clks;
    return (longest > 1) ? $clog2(longest) : 1;
  endfunction

endpackage

// File: rtl/serial_transmit_if.sv
// Word handshake and line status between a word source and serial_transmit.
interface serial_transmit_if;
  import serial_pkg::*;

  logic [DATA_BITS-1:0] DataIn;
  logic                 InValid;
  logic                 Ready;
  logic                 Transmit;
  logic                 Busy;
  logic                 Done;

  modport master (
    output DataIn,
    output InValid,
    input  Ready,
    input  Transmit,
    input  Busy,
    input  Done
  );

  modport slave (
    input  DataIn,
    input  InValid,
    output Ready,
    output Transmit,
    output Busy,
    output Done
  );

endinterface

// File: rtl/serial_bit_timer.sv
// Per-state clock counter: counts 0..last, flags the final clock and wraps to 0.
module serial_bit_timer #(
  parameter int CNT_W = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             clear,
  input  logic [CNT_W-1:0] last,
  output logic             tick,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;

  assign tick  = (count_r == last);
  assign count = count_r;

  // Clock counter, held at zero while idle and wrapped at each period end.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear || tick) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      count_r <= count_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_transmit.sv
// 16-bit serial transmitter: start bit, LSB-first data, long stop guard,
// with a one-word hold register so frames can run back to back.
module serial_transmit
  import serial_pkg::*;
#(
  parameter int BIT_CLKS  = DEF_BIT_CLKS,
  parameter int STOP_CLKS = DEF_STOP_CLKS
) (
  input  logic             Clock,
  input  logic             Reset,
  serial_transmit_if.slave bus
);

  localparam int               CNT_W       = count_width(BIT_CLKS, STOP_CLKS);
  localparam int               BIT_W       = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST    = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] STOP_LAST   = CNT_W'(STOP_CLKS - 1);
  // Done is registered, so it is raised one clock before the final stop clock.
  localparam logic [CNT_W-1:0] STOP_PENULT = CNT_W'(STOP_CLKS - 2);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_BITS - 1);

  serial_state_t        state_r;
  serial_state_t        state_s;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_s;
  logic [DATA_BITS-1:0] hold_r;
  logic [DATA_BITS-1:0] hold_s;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic [BIT_W-1:0]     bit_cnt_s;
  logic                 ready_r;
  logic                 ready_s;
  logic                 tx_r;
  logic                 tx_s;
  logic                 busy_r;
  logic                 busy_s;
  logic                 done_r;
  logic                 done_s;

  logic                 accept_s;
  logic                 direct_load_s;
  logic                 tick_s;
  logic                 timer_clear_s;
  logic [CNT_W-1:0]     timer_last_s;
  logic [CNT_W-1:0]     count_s;

  assign accept_s      = bus.InValid && ready_r;
  assign timer_clear_s = (state_r == IDLE);
  assign timer_last_s  = (state_r == STOP) ? STOP_LAST : BIT_LAST;
  // A word goes straight to the shifter only when the line is free this edge.
  assign direct_load_s = (state_r == IDLE) ||
                         ((state_r == STOP) && tick_s && ready_r);

  serial_bit_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .Clock (Clock),
    .Reset (Reset),
    .clear (timer_clear_s),
    .last  (timer_last_s),
    .tick  (tick_s),
    .count (count_s)
  );

  // Next-state, shifter, hold register and line-level decode.
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    hold_s    = hold_r;
    bit_cnt_s = bit_cnt_r;
    ready_s   = ready_r;

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s   = START;
          shift_s   = bus.DataIn;
          bit_cnt_s = {BIT_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          state_s = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
          if (bit_cnt_r == LAST_BIT) begin
            state_s   = STOP;
            bit_cnt_s = {BIT_W{1'b0}};
          end else begin
            bit_cnt_s = bit_cnt_r + BIT_W'(1);
          end
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        if (tick_s) begin
          bit_cnt_s = {BIT_W{1'b0}};
          if (!ready_r) begin
            state_s = START;
            shift_s = hold_r;
            ready_s = 1'b1;
          end else if (accept_s) begin
            state_s = START;
            shift_s = bus.DataIn;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s   = IDLE;
        bit_cnt_s = {BIT_W{1'b0}};
        ready_s   = 1'b1;
      end
    endcase

    if (accept_s && !direct_load_s) begin
      hold_s  = bus.DataIn;
      ready_s = 1'b0;
    end else begin
      hold_s = hold_s;
    end

    case (state_s)
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
      IDLE:    tx_s = 1'b1;
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase

    busy_s = (state_s != IDLE);
    done_s = (state_r == STOP) && (count_s == STOP_PENULT);
  end

  // State and output registers; reset abandons any frame and held word.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r   <= IDLE;
      shift_r   <= {DATA_BITS{1'b0}};
      hold_r    <= {DATA_BITS{1'b0}};
      bit_cnt_r <= {BIT_W{1'b0}};
      ready_r   <= 1'b1;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      hold_r    <= hold_s;
      bit_cnt_r <= bit_cnt_s;
      ready_r   <= ready_s;
      tx_r      <= tx_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  assign bus.Ready    = ready_r;
  assign bus.Transmit = tx_r;
  assign bus.Busy     = busy_r;
  assign bus.Done     = done_r;

endmodule

// File: tb/tb_serial_transmit.sv
// Directed and random stimulus for serial_transmit, checked cycle by cycle
// against a frame-position model and a behavioural line receiver.
module tb_serial_transmit;
  import serial_pkg::*;

  localparam int BITC  = 8;
  localparam int STOPC = 16;
  localparam int FRAME = BITC * (DATA_BITS + 1) + STOPC;
  localparam int DATA_END = BITC * (DATA_BITS + 1);

  logic Clock = 1'b0;
  logic Reset;

  serial_transmit_if bus_if ();

  serial_transmit #(
    .BIT_CLKS  (BITC),
    .STOP_CLKS (STOPC)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_if)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  // Model: position inside the current frame (0 = idle, 1..FRAME), pending words.
  int          m_pos;
  logic [15:0] m_word;
  logic [15:0] m_hold_q[$];
  logic [15:0] m_sent_q[$];
  logic        m_acc;

  // Line receiver: samples each bit mid-period, checks the stop level.
  logic [15:0] rx_q[$];
  logic [15:0] rx_sh = 16'h0000;
  int          rx_cnt = 0;
  bit          rx_busy = 1'b0;
  int          rx_errs = 0;

  always @(negedge Clock) begin
    if (Reset) begin
      rx_busy <= 1'b0;
      rx_cnt  <= 0;
    end else if (!rx_busy) begin
      if (bus_if.Transmit === 1'b0) begin
        rx_busy <= 1'b1;
        rx_cnt  <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if ((rx_cnt + 1 >= BITC + BITC / 2) && (rx_cnt + 1 <= DATA_END) &&
          (((rx_cnt + 1 - BITC - BITC / 2) % BITC) == 0)) begin
        rx_sh <= {bus_if.Transmit, rx_sh[15:1]};
      end
      if (rx_cnt + 1 == DATA_END + STOPC / 2) begin
        if (bus_if.Transmit === 1'b1) rx_q.push_back(rx_sh);
        else rx_errs <= rx_errs + 1;
        rx_busy <= 1'b0;
      end
    end
  end

  task automatic model_reset();
    m_pos = 0;
    m_hold_q.delete();
  endtask

  task automatic model_edge(input logic acc, input logic [15:0] din);
    if (m_pos == 0 || m_pos == FRAME) begin
      if (m_pos == FRAME) m_sent_q.push_back(m_word);
      if (m_hold_q.size() != 0) begin
        m_word = m_hold_q.pop_front();
        m_pos  = 1;
      end else if (acc) begin
        m_word = din;
        m_pos  = 1;
      end else begin
        m_pos = 0;
      end
    end else begin
      m_pos++;
      if (acc) m_hold_q.push_back(din);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic etx;
    if (m_pos == 0) etx = 1'b1;
    else if (m_pos <= BITC) etx = 1'b0;
    else if (m_pos <= DATA_END) etx = m_word[(m_pos - BITC - 1) / BITC];
    else etx = 1'b1;
    total++;
    assert (bus_if.Transmit === etx) else begin
      bad++;
      $error("FAIL %s.tx pos=%0d got=%b exp=%b", tag, m_pos, bus_if.Transmit, etx);
    end
    total++;
    assert (bus_if.Busy === (m_pos != 0)) else begin
      bad++;
      $error("FAIL %s.busy pos=%0d got=%b exp=%b", tag, m_pos, bus_if.Busy, (m_pos != 0));
    end
    total++;
    assert (bus_if.Done === (m_pos == FRAME)) else begin
      bad++;
      $error("FAIL %s.done pos=%0d got=%b exp=%b", tag, m_pos, bus_if.Done, (m_pos == FRAME));
    end
    total++;
    assert (bus_if.Ready === (m_hold_q.size() == 0)) else begin
      bad++;
      $error("FAIL %s.ready pos=%0d got=%b exp=%b", tag, m_pos, bus_if.Ready,
             (m_hold_q.size() == 0));
    end
  endtask

  task automatic step(input string tag);
    logic [15:0] din;
    @(posedge Clock);
    m_acc = bus_if.InValid && (m_hold_q.size() == 0) && !Reset;
    din   = bus_if.DataIn;
    if (Reset) model_reset();
    else model_edge(m_acc, din);
    @(negedge Clock);
    check_outputs(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      bus_if.DataIn = 16'($urandom);
      step(tag);
    end
  endtask

  task automatic send(input logic [15:0] w, input string tag);
    bus_if.DataIn  = w;
    bus_if.InValid = 1'b1;
    step(tag);
    bus_if.InValid = 1'b0;
  endtask

  task automatic run_until_pos(input int p, input string tag);
    bit found;
    found = (m_pos == p);
    for (int i = 0; i < 2 * FRAME + 10 && !found; i++) begin
      step(tag);
      found = (m_pos == p);
    end
    total++;
    assert (found === 1'b1) else begin
      bad++;
      $error("FAIL %s.timeout got=pos%0d exp=pos%0d", tag, m_pos, p);
    end
  endtask

  task automatic wait_idle(input string tag);
    bit idle;
    idle = (m_pos == 0) && (m_hold_q.size() == 0);
    for (int i = 0; i < 4 * FRAME && !idle; i++) begin
      step(tag);
      idle = (m_pos == 0) && (m_hold_q.size() == 0);
    end
    total++;
    assert (idle === 1'b1) else begin
      bad++;
      $error("FAIL %s.idle_timeout got=pos%0d exp=0", tag, m_pos);
    end
    run(4, tag);
  endtask

  initial begin
    logic [15:0] w;
    bit          taken;

    Reset          = 1'b1;
    bus_if.InValid = 1'b0;
    bus_if.DataIn  = 16'h0000;
    m_word         = 16'h0000;
    m_acc          = 1'b0;
    model_reset();
    step("reset");
    step("reset");

    // First accept right after reset release, reference frame 16'hA5C3.
    Reset = 1'b0;
    send(16'hA5C3, "a5c3");
    run(FRAME + 4, "a5c3");

    send(16'h0000, "w0000");
    run(FRAME + 3, "w0000");
    send(16'hFFFF, "wffff");
    run(FRAME + 3, "wffff");
    send(16'h8001, "w8001");
    run(FRAME + 3, "w8001");

    // Second word held during frame 1; third waits (InValid held) for Ready.
    send(16'h1234, "b2b");
    run(20, "b2b");
    send(16'h5678, "b2b");
    bus_if.DataIn  = 16'h9ABC;
    bus_if.InValid = 1'b1;
    taken = 1'b0;
    for (int i = 0; i < 2 * FRAME && !taken; i++) begin
      step("retry");
      taken = m_acc;
    end
    bus_if.InValid = 1'b0;
    total++;
    assert (taken === 1'b1) else begin
      bad++;
      $error("FAIL retry.accept got=%b exp=1", taken);
    end
    wait_idle("b2b");

    // Accept on the final stop edge with the hold empty.
    send(16'hC0DE, "laststop");
    run_until_pos(FRAME, "laststop");
    w = 16'($urandom);
    send(w, "laststop");
    run(FRAME + 3, "laststop");
    wait_idle("laststop");

    for (int i = 0; i < 700; i++) begin
      bus_if.InValid = ($urandom_range(0, 99) < 3);
      bus_if.DataIn  = 16'($urandom);
      step("rand");
    end
    bus_if.InValid = 1'b0;
    wait_idle("rand");

    // Reset at clock 70 with a word held, then a fresh word.
    send(16'($urandom), "midrst");
    run_until_pos(30, "midrst");
    send(16'($urandom), "midrst");
    run_until_pos(70, "midrst");
    #2 Reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    step("rst_hold");
    step("rst_hold");
    Reset = 1'b0;
    send(16'h00FF, "w00ff");
    run(FRAME + 3, "w00ff");
    wait_idle("w00ff");

    total++;
    assert (rx_q.size() === m_sent_q.size()) else begin
      bad++;
      $error("FAIL rx.count got=%0d exp=%0d", rx_q.size(), m_sent_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < m_sent_q.size(); i++) begin
      total++;
      assert (rx_q[i] === m_sent_q[i]) else begin
        bad++;
        $error("FAIL rx.word%0d got=%h exp=%h", i, rx_q[i], m_sent_q[i]);
      end
    end
    total++;
    assert (rx_errs === 0) else begin
      bad++;
      $error("FAIL rx.stop_errors got=%0d exp=0", rx_errs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
